write_select_sequencer: RTL and testbench

- Control sequencer directly upstream of the register write-enable decoder.
- Steps the basic-computer fetch/decode/execute cycle and drives a 3-bit write select plus a write enable; the decoder turns the select into one-hot AC/AR/DR/IR/PC/R/TR/Write strobes.
- Also drives a PC increment and a memory-read request, and handshakes with memory via mem_ready.

---
 rtl/seq_pkg.sv | 37 +++
 rtl/seq_step_counter.sv | 19 +
 rtl/write_select_sequencer.sv | 161 ++++++++++++++++
 tb/tb_write_select_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared codes for the write-select sequencer and the register write-enable decoder.
package seq_pkg;

  localparam logic [2:0] SEL_AC    = 3'b000;
  localparam logic [2:0] SEL_AR    = 3'b001;
  localparam logic [2:0] SEL_DR    = 3'b010;
  localparam logic [2:0] SEL_IR    = 3'b011;
  localparam logic [2:0] SEL_PC    = 3'b100;
  localparam logic [2:0] SEL_R     = 3'b101;
  localparam logic [2:0] SEL_TR    = 3'b110;
  localparam logic [2:0] SEL_MEMWR = 3'b111;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_STA = 3'd2;
  localparam logic [2:0] OP_JMP = 3'd3;
  localparam logic [2:0] OP_JZ  = 3'd4;
  localparam logic [2:0] OP_HLT = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_EX0, S_LD1, S_LD2, S_ST1, S_HALT
  } state_e;

  // cap: write_en follows mem_ready so the DR capture lands on the completion cycle
  typedef struct packed {
    logic [2:0] sel;
    logic       wen;
    logic       inc;
    logic       rd;
    logic       cap;
  } strobe_t;

  function automatic logic is_mem_wait(input state_e s);
    return (s == S_F1) || (s == S_LD1) || (s == S_ST1);
  endfunction

endpackage

// File: rtl/seq_step_counter.sv
// Saturating up-counter with synchronous clear; used for the T-step and the memory wait count.
module seq_step_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/write_select_sequencer.sv
// Fetch/decode/execute sequencer driving the register write-select decoder.
// Optional memory-wait timeout: define SEQ_MEM_TIMEOUT_EN.
module write_select_sequencer
  import seq_pkg::*;
#(
  parameter int OPW         = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           ac_zero,
  input  logic           mem_ready,
  output logic [2:0]     write_sel,
  output logic           write_en,
  output logic           inc_pc,
  output logic           mem_read,
  output logic [2:0]     step,
  output logic           halted,
  output logic           err
);

  state_e         state_q, state_d;
  strobe_t        stb_q, stb_d;
  logic [OPW-1:0] op_q;
  logic           halted_q, err_q, err_set;
  logic           waiting, timeout;

  assign waiting = is_mem_wait(state_q);

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  // any state change clears, so every entry into a wait state starts from zero
  seq_step_counter #(.W(TW)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_d != state_q),
    .en  (waiting && !mem_ready),
    .cnt (wait_cnt)
  );

  assign timeout = waiting && !mem_ready && (wait_cnt == TW'(MEM_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stb_d   = '0;
    err_set = timeout;

    case (state_q)
      S_IDLE: if (start) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1: begin
        if (mem_ready)    state_d = S_F2;
        else if (timeout) state_d = S_F0;
      end
      S_F2:   state_d = S_DEC;
      S_DEC:  state_d = S_EX0;
      S_EX0: begin
        case (op_q)
          OPW'(OP_LDA): state_d = S_LD1;
          OPW'(OP_STA): state_d = S_ST1;
          OPW'(OP_HLT): state_d = S_HALT;
          default:      state_d = S_F0;
        endcase
      end
      S_LD1: begin
        if (mem_ready)    state_d = S_LD2;
        else if (timeout) state_d = S_F0;
      end
      S_LD2:  state_d = S_F0;
      S_ST1:  if (mem_ready || timeout) state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // strobes are registered for the state being entered
    case (state_d)
      S_F0: begin
        stb_d.sel = SEL_AR;
        stb_d.wen = 1'b1;
      end
      S_F1, S_LD1: begin
        stb_d.sel = SEL_DR;
        stb_d.rd  = 1'b1;
        stb_d.cap = 1'b1;
      end
      S_F2: begin
        stb_d.sel = SEL_IR;
        stb_d.wen = 1'b1;
        stb_d.inc = 1'b1;
      end
      S_EX0: begin
        // EX0 is only entered from DEC, where opcode and ac_zero are live
        case (opcode)
          OPW'(OP_LDA), OPW'(OP_STA): begin
            stb_d.sel = SEL_AR;
            stb_d.wen = 1'b1;
          end
          OPW'(OP_JMP): begin
            stb_d.sel = SEL_PC;
            stb_d.wen = 1'b1;
          end
          OPW'(OP_JZ): begin
            stb_d.sel = SEL_PC;
            stb_d.wen = ac_zero;
          end
          OPW'(OP_NOP), OPW'(OP_HLT): ;
          default: err_set = 1'b1;
        endcase
      end
      S_LD2: begin
        stb_d.sel = SEL_AC;
        stb_d.wen = 1'b1;
      end
      S_ST1: begin
        stb_d.sel = SEL_MEMWR;
        stb_d.wen = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stb_q    <= '0;
      op_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      if (state_q == S_DEC) op_q <= opcode;
      halted_q <= halted_q | (state_d == S_HALT);
      err_q    <= err_q | err_set;
    end
  end

  // step holds at zero outside an instruction and restarts at every fetch
  seq_step_counter #(.W(3)) u_step (
    .clk (clk),
    .rst (rst),
    .clr ((state_d == S_F0) || (state_d == S_IDLE)),
    .en  (1'b1),
    .cnt (step)
  );

  assign write_sel = stb_q.sel;
  assign write_en  = stb_q.wen | (stb_q.cap & mem_ready);
  assign inc_pc    = stb_q.inc;
  assign mem_read  = stb_q.rd;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_write_select_sequencer.sv
// Randomized instruction-stream bench; expected strobes come from per-instruction phase rules.
module tb_write_select_sequencer;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, ac_zero, mem_ready;
  logic [2:0] opcode;
  logic [2:0] write_sel, step;
  logic       write_en, inc_pc, mem_read, halted, err;

  always #5 clk = ~clk;

  write_select_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ac_zero(ac_zero),
    .mem_ready(mem_ready), .write_sel(write_sel), .write_en(write_en),
    .inc_pc(inc_pc), .mem_read(mem_read), .step(step), .halted(halted), .err(err)
  );

  int         total = 0, bad = 0;
  logic [2:0] st_exp;
  logic       halted_exp, err_exp, busy;

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (sel,en,inc,rd,step,halted,err)", tag, obs, exp);
    end
  endtask

  function automatic logic junk();
    return 1'($urandom_range(0, 1));
  endfunction

  // one clock: drive mem_ready, compare outputs, advance; sel ignored when dc
  task automatic cyc(input string tag, input logic rdy, input logic [2:0] sel, input logic dc,
                     input logic en, input logic inc, input logic rd);
    logic [10:0] obs;
    mem_ready = rdy;
    if (busy) start = junk();
    #1;
    obs = {write_sel, write_en, inc_pc, mem_read, step, halted, err};
    if (dc) obs[10:8] = sel;
    chk(tag, obs, {sel, en, inc, rd, st_exp, halted_exp, err_exp});
    @(posedge clk); #1;
    if (st_exp != 3'd7) st_exp = st_exp + 3'd1;
  endtask

  function automatic logic pick(input int n, input int dly);
    if (dly >= 0) return (n == dly);
    return (n >= 8) || ($urandom_range(0, 2) == 0);
  endfunction

  task automatic mem_wait(input string tag, input int dly, input logic store);
    int   n = 0;
    logic r;
    do begin
      r = pick(n, dly);
      if (store) cyc(tag, r, SEL_MEMWR, 1'b0, 1'b1, 1'b0, 1'b0);
      else       cyc(tag, r, SEL_DR, !r, r, 1'b0, 1'b1);
      n++;
    end while (!r);
  endtask

  task automatic front(input logic [2:0] op, input logic acz, input int dly);
    st_exp = 3'd0;
    cyc("F0", junk(), SEL_AR, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_wait("F1", dly, 1'b0);
    cyc("F2", junk(), SEL_IR, 1'b0, 1'b1, 1'b1, 1'b0);
    opcode  = op;
    ac_zero = acz;
    cyc("DEC", junk(), SEL_AC, 1'b1, 1'b0, 1'b0, 1'b0);
    case (op)
      OP_LDA, OP_STA: cyc("EX0", junk(), SEL_AR, 1'b0, 1'b1, 1'b0, 1'b0);
      OP_JMP:         cyc("EX0", junk(), SEL_PC, 1'b0, 1'b1, 1'b0, 1'b0);
      OP_JZ:          cyc("EX0_jz", junk(), SEL_PC, !acz, acz, 1'b0, 1'b0);
      OP_NOP, OP_HLT: cyc("EX0", junk(), SEL_AC, 1'b1, 1'b0, 1'b0, 1'b0);
      default: begin
        err_exp = 1'b1;
        cyc("EX0_ill", junk(), SEL_AC, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    endcase
  endtask

  task automatic run_instr(input logic [2:0] op, input logic acz, input int d1, input int d2);
    front(op, acz, d1);
    case (op)
      OP_LDA: begin
        mem_wait("LD1", d2, 1'b0);
        cyc("LD2", junk(), SEL_AC, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      OP_STA: mem_wait("ST1", d2, 1'b1);
      OP_HLT: begin
        halted_exp = 1'b1;
        repeat (6) cyc("HALT", junk(), SEL_AC, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      default: ;
    endcase
  endtask

  task automatic idle(input string tag, input logic go);
    busy   = 1'b0;
    start  = go;
    st_exp = 3'd0;
    cyc(tag, junk(), SEL_AC, 1'b0, 1'b0, 1'b0, 1'b0);
    if (go) busy = 1'b1;
  endtask

  initial begin
    logic [2:0] op;
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; opcode = '0; ac_zero = 1'b0;
    busy = 1'b0; st_exp = 3'd0; halted_exp = 1'b0; err_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 1'b0, SEL_AC, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle("idle", 1'b0);
    idle("idle_go", 1'b1);

    run_instr(OP_NOP, 1'b0, 0, 0);
    run_instr(OP_LDA, 1'b0, 0, 3);
    run_instr(OP_JZ,  1'b1, -1, -1);
    run_instr(OP_JZ,  1'b0, -1, -1);
    run_instr(OP_JMP, 1'b0, -1, -1);
    run_instr(OP_STA, 1'b0, -1, 2);
    run_instr(3'd6,   1'b0, -1, -1);
    run_instr(OP_NOP, 1'b0, 2, 0);

`ifdef SEQ_MEM_TIMEOUT_EN
    st_exp = 3'd0;
    cyc("F0_to", junk(), SEL_AR, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (15) cyc("F1_to", 1'b0, SEL_DR, 1'b1, 1'b0, 1'b0, 1'b1);
    err_exp = 1'b1;
    run_instr(OP_NOP, 1'b0, 0, 0);
`endif

    repeat (50) begin
      op = 3'($urandom_range(0, 7));
      if (op == OP_HLT) op = OP_LDA;
      run_instr(op, junk(), -1, -1);
    end

    run_instr(OP_HLT, 1'b0, -1, -1);
    busy = 1'b0; start = 1'b0; rst = 1'b1;
    cyc("HALT_rst", junk(), SEL_AC, 1'b1, 1'b0, 1'b0, 1'b0);
    halted_exp = 1'b0; err_exp = 1'b0; rst = 1'b0;
    idle("post_halt", 1'b0);
    idle("go2", 1'b1);

    front(OP_STA, 1'b0, -1);
    cyc("ST1", 1'b0, SEL_MEMWR, 1'b0, 1'b1, 1'b0, 1'b0);
    busy = 1'b0; start = 1'b0; rst = 1'b1;
    cyc("ST1_rst", 1'b0, SEL_MEMWR, 1'b0, 1'b1, 1'b0, 1'b0);
    halted_exp = 1'b0; err_exp = 1'b0; rst = 1'b0;
    idle("post_st_rst", 1'b0);
    idle("go3", 1'b1);
    run_instr(OP_LDA, 1'b1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
